// File: rtl/memoria_dados_pkg.sv
// Shared constants and types for the data memory of the load/store stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package memoria_dados_pkg;

  localparam int DATA_W             = 32;
  localparam int MEM_DEPTH_DEFAULT  = 256;
  localparam int BYTES_PER_WORD     = 4;
  localparam int LANE_W             = 8;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/byte_lane_merge.sv
// Merges a new word into an old word lane by lane under a byte-enable mask.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
// Ports: old_word (current stored word), new_word (incoming data),
//        be (one bit per 8-bit lane, 1 = take new lane), merged (result).
module byte_lane_merge
  import memoria_dados_pkg::*;
(
  input  word_t                     old_word,
  input  word_t                     new_word,
  input  logic [BYTES_PER_WORD-1:0] be,
  output word_t                     merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (be[i]) begin
        merged[i*LANE_W +: LANE_W] = new_word[i*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: rtl/memoria_dados_ram.sv
// Word-indexed data memory: one synchronous write port, one combinational read port, shared address.
// Latency: read 0 cycles (combinational from rs); write visible after the rising edge.
// Backpressure: none; every cycle accepts one read and at most one write.
// Ports: clk, rst_n (synchronous, active-low, clears every word), rs (word index; upper bits
//        ignored and flagged on addr_err), wd (write data), wr (write enable), rd (read data).
// Optional macro MEMORIA_DADOS_BYTE_EN_EN adds input be[3:0] for per-lane write enables.
module memoria_dados_ram
  import memoria_dados_pkg::*;
#(
  parameter int DEPTH  = MEM_DEPTH_DEFAULT,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] rs,
  input  logic [31:0] wd,
  input  logic        wr,
`ifdef MEMORIA_DADOS_BYTE_EN_EN
  input  logic [3:0]  be,
`endif
  output logic [31:0] rd,
  output logic        addr_err
);

  word_t                     mem [DEPTH];
  logic [ADDR_W-1:0]         idx;
  word_t                     cur_word;
  word_t                     merged_word;
  logic [BYTES_PER_WORD-1:0] be_eff;

  // Upper index bits are dropped, so out-of-range addresses alias modulo DEPTH.
  assign idx      = rs[ADDR_W-1:0];
  assign cur_word = mem[idx];
  assign rd       = cur_word;
  assign addr_err = |rs[31:ADDR_W];

`ifdef MEMORIA_DADOS_BYTE_EN_EN
  assign be_eff = be;
`else
  // Without byte enables every write covers the whole word.
  assign be_eff = '1;
`endif

  byte_lane_merge u_merge (
    .old_word (cur_word),
    .new_word (wd),
    .be       (be_eff),
    .merged   (merged_word)
  );

  // Reset wins over a same-edge write. With be=0 the merge returns the old
  // word, so the write is a harmless no-op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr) begin
      mem[idx] <= merged_word;
    end
  end

endmodule

// File: tb/tb_memoria_dados_ram.sv
module tb_memoria_dados_ram;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rs;
  logic [31:0] wd;
  logic        wr;
  logic [31:0] rd;
  logic        addr_err;
`ifdef MEMORIA_DADOS_BYTE_EN_EN
  logic [3:0]  be;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] model [DEPTH];

  always #5 clk = ~clk;

  memoria_dados_ram #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs       (rs),
    .wd       (wd),
    .wr       (wr),
`ifdef MEMORIA_DADOS_BYTE_EN_EN
    .be       (be),
`endif
    .rd       (rd),
    .addr_err (addr_err)
  );

  typedef struct {
    logic        rst_n;
    logic        wr;
    logic [31:0] rs;
    logic [31:0] wd;
    logic [31:0] exp_pre;
    logic [31:0] exp_post;
    logic        exp_err;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    rst_n = r;
    wr    = w;
    rs    = a;
    wd    = d;
    #1;
  endtask

  task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h expected %h", name, n, act, exp);
    end
  endtask

  // Reference model step for one rising edge.
  task automatic model_edge(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] lanes);
    if (!r) begin
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    end else if (w) begin
      for (int b = 0; b < 4; b++)
        if (lanes[b]) model[a % DEPTH][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [];
    logic        r, w;
    logic [31:0] a, d;
    logic [3:0]  lanes;

    vecs = new[19];
    //          rst wr  rs            wd            pre           post          err
    vecs[0]  = '{1, 0, 32'd0,        32'h0,        32'h0,        32'h0,        0};
    vecs[1]  = '{1, 0, 32'd1,        32'h0,        32'h0,        32'h0,        0};
    vecs[2]  = '{1, 0, 32'd2,        32'h0,        32'h0,        32'h0,        0};
    vecs[3]  = '{1, 0, 32'd3,        32'h0,        32'h0,        32'h0,        0};
    vecs[4]  = '{1, 1, 32'd0,        32'hFEEDF00D, 32'h0,        32'hFEEDF00D, 0};
    vecs[5]  = '{1, 1, 32'd1,        32'hBEEFCAFE, 32'h0,        32'hBEEFCAFE, 0};
    vecs[6]  = '{1, 0, 32'd0,        32'h0,        32'hFEEDF00D, 32'hFEEDF00D, 0};
    vecs[7]  = '{1, 1, 32'd5,        32'h12345678, 32'h0,        32'h12345678, 0};
    vecs[8]  = '{1, 0, 32'd5,        32'h0,        32'h12345678, 32'h12345678, 0};
    vecs[9]  = '{1, 1, 32'd256,      32'hA5A5A5A5, 32'hFEEDF00D, 32'hA5A5A5A5, 1};
    vecs[10] = '{1, 0, 32'd0,        32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5, 0};
    vecs[11] = '{1, 0, 32'd1,        32'h0,        32'hBEEFCAFE, 32'hBEEFCAFE, 0};
    vecs[12] = '{1, 0, 32'hFFFFFF01, 32'h0,        32'hBEEFCAFE, 32'hBEEFCAFE, 1};
    vecs[13] = '{1, 0, 32'd255,      32'h0,        32'h0,        32'h0,        0};
    vecs[14] = '{0, 1, 32'd5,        32'hFFFFFFFF, 32'h12345678, 32'h0,        0};
    vecs[15] = '{1, 0, 32'd5,        32'h0,        32'h0,        32'h0,        0};
    vecs[16] = '{1, 0, 32'd0,        32'h0,        32'h0,        32'h0,        0};
    vecs[17] = '{1, 0, 32'd1,        32'h0,        32'h0,        32'h0,        0};
    vecs[18] = '{1, 0, 32'h80000000, 32'h0,        32'h0,        32'h0,        1};

`ifdef MEMORIA_DADOS_BYTE_EN_EN
    be = 4'hF;
`endif
    apply(1'b0, 1'b0, 32'd0, 32'd0);
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst_n, vecs[i].wr, vecs[i].rs, vecs[i].wd);
      chk("vec_rd_pre", i, rd, vecs[i].exp_pre);
      chk("vec_err", i, {31'b0, addr_err}, {31'b0, vecs[i].exp_err});
      tick();
      chk("vec_rd_post", i, rd, vecs[i].exp_post);
    end

    // Read port follows rs with no clock edge in between.
    apply(1'b1, 1'b1, 32'd0, 32'hFEEDF00D);
    tick();
    apply(1'b1, 1'b1, 32'd1, 32'hBEEFCAFE);
    tick();
    apply(1'b1, 1'b0, 32'd0, 32'h0);
    chk("comb_rd0", 0, rd, 32'hFEEDF00D);
    rs = 32'd1;
    #1;
    chk("comb_rd1", 0, rd, 32'hBEEFCAFE);
    rs = 32'd0;
    #1;
    chk("comb_rd0b", 0, rd, 32'hFEEDF00D);

`ifdef MEMORIA_DADOS_BYTE_EN_EN
    be = 4'hF;
    apply(1'b1, 1'b1, 32'd2, 32'h11223344);
    tick();
    be = 4'b0101;
    apply(1'b1, 1'b1, 32'd2, 32'hAABBCCDD);
    chk("be_pre", 0, rd, 32'h11223344);
    tick();
    chk("be_0101", 0, rd, 32'h11BB33DD);
    be = 4'b0000;
    apply(1'b1, 1'b1, 32'd2, 32'h99999999);
    tick();
    chk("be_0000", 0, rd, 32'h11BB33DD);
`endif

    // Randomised phase against the array model; start from a known cleared state.
    apply(1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

    for (int n = 0; n < 600; n++) begin
      r = ($urandom_range(0, 59) != 0);
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       a = $urandom;
        1, 2:    a = $urandom_range(0, DEPTH - 1);
        default: a = $urandom_range(0, 15);
      endcase
      d = $urandom;
`ifdef MEMORIA_DADOS_BYTE_EN_EN
      lanes = 4'($urandom_range(0, 15));
      be    = lanes;
`else
      lanes = 4'hF;
`endif
      apply(r, w, a, d);
      chk("rnd_rd_pre", n, rd, model[a % DEPTH]);
      chk("rnd_err", n, {31'b0, addr_err}, {31'b0, (a >= DEPTH)});
      tick();
      model_edge(r, w, a, d, lanes);
      chk("rnd_rd_post", n, rd, model[a % DEPTH]);
    end

    // Full sweep of the array against the model, then a reset with wr=1.
    apply(1'b1, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      rs = i;
      #1;
      chk("sweep", i, rd, model[i]);
    end

    apply(1'b0, 1'b1, 32'd7, 32'hFFFFFFFF);
    tick();
    apply(1'b1, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      rs = i;
      #1;
      chk("reset_sweep", i, rd, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
